// File: rtl/alu_writeback_psr_pkg.sv
// Shared definitions for the ALU writeback/PSR stage: opcodes, flag indices,
// condition codes, PSR update masks and opcode classification helpers.
package alu_writeback_psr_pkg;

  localparam logic [7:0] ADD    = 8'h00;
  localparam logic [7:0] ADDI   = 8'h01;
  localparam logic [7:0] ADDU   = 8'h02;
  localparam logic [7:0] ADDUI  = 8'h03;
  localparam logic [7:0] ADDC   = 8'h04;
  localparam logic [7:0] ADDCI  = 8'h05;
  localparam logic [7:0] ADDCU  = 8'h06;
  localparam logic [7:0] ADDCUI = 8'h07;
  localparam logic [7:0] SUB    = 8'h08;
  localparam logic [7:0] SUBI   = 8'h09;
  localparam logic [7:0] CMP    = 8'h0A;
  localparam logic [7:0] CMPI   = 8'h0B;
  localparam logic [7:0] CMPU   = 8'h0C;
  localparam logic [7:0] CMPUI  = 8'h0D;
  localparam logic [7:0] AND    = 8'h0E;
  localparam logic [7:0] ANDI   = 8'h0F;
  localparam logic [7:0] OR     = 8'h10;
  localparam logic [7:0] ORI    = 8'h11;
  localparam logic [7:0] XOR    = 8'h12;
  localparam logic [7:0] XORI   = 8'h13;
  localparam logic [7:0] NOT    = 8'h14;
  localparam logic [7:0] LSH    = 8'h15;
  localparam logic [7:0] LSHI   = 8'h16;
  localparam logic [7:0] RSH    = 8'h17;
  localparam logic [7:0] RSHI   = 8'h18;
  localparam logic [7:0] ALSH   = 8'h19;
  localparam logic [7:0] ALSHI  = 8'h1A;
  localparam logic [7:0] ARSH   = 8'h1B;
  localparam logic [7:0] ARSHI  = 8'h1C;
  localparam logic [7:0] NOP    = 8'h1D;

  localparam int FLG_N = 0;
  localparam int FLG_L = 1;
  localparam int FLG_F = 2;
  localparam int FLG_C = 3;
  localparam int FLG_Z = 4;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_LO = 4'b0100;
  localparam logic [3:0] CC_HS = 4'b0101;
  localparam logic [3:0] CC_LT = 4'b0110;
  localparam logic [3:0] CC_GE = 4'b0111;
  localparam logic [3:0] CC_FS = 4'b1000;
  localparam logic [3:0] CC_FC = 4'b1001;
  localparam logic [3:0] CC_GT = 4'b1010;
  localparam logic [3:0] CC_LE = 4'b1011;
  localparam logic [3:0] CC_UC = 4'b1110;

  localparam logic [4:0] MASK_ARITH_U = 5'b11000;  // C,Z
  localparam logic [4:0] MASK_ARITH_S = 5'b10100;  // F,Z
  localparam logic [4:0] MASK_CMP     = 5'b10011;  // N,L,Z
  localparam logic [4:0] MASK_LOGIC   = 5'b10000;  // Z
  localparam logic [4:0] MASK_NONE    = 5'b00000;

  typedef enum logic {ST_IDLE, ST_HOLD} wb_state_t;

  function automatic logic [4:0] psr_update_mask(input logic [7:0] op);
    case (op)
      ADDU, ADDUI, ADDCU, ADDCUI:            return MASK_ARITH_U;
      ADD, ADDI, ADDC, ADDCI, SUB, SUBI:     return MASK_ARITH_S;
      CMP, CMPI, CMPU, CMPUI:                return MASK_CMP;
      AND, ANDI, OR, ORI, XOR, XORI, NOT:    return MASK_LOGIC;
      default:                               return MASK_NONE;
    endcase
  endfunction

  // Compares, NOP and anything undecoded never touch the register file.
  function automatic logic op_is_writeback(input logic [7:0] op);
    case (op)
      CMP, CMPI, CMPU, CMPUI, NOP: return 1'b0;
      default:                     return (op < NOP);
    endcase
  endfunction

endpackage

// File: rtl/alu_writeback_psr_cond_eval.sv
// Combinational branch-condition evaluation of a PSR value; reusable by the branch unit.
module alu_writeback_psr_cond_eval
  import alu_writeback_psr_pkg::*;
(
  input  logic [4:0] psr,
  input  logic [3:0] cond,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      CC_EQ: cond_true = psr[FLG_Z];
      CC_NE: cond_true = !psr[FLG_Z];
      CC_CS: cond_true = psr[FLG_C];
      CC_CC: cond_true = !psr[FLG_C];
      CC_LO: cond_true = psr[FLG_L];
      CC_HS: cond_true = !psr[FLG_L];
      CC_LT: cond_true = psr[FLG_N];
      CC_GE: cond_true = !psr[FLG_N];
      CC_FS: cond_true = psr[FLG_F];
      CC_FC: cond_true = !psr[FLG_F];
      CC_GT: cond_true = !psr[FLG_N] && !psr[FLG_Z];
      CC_LE: cond_true = psr[FLG_N] || psr[FLG_Z];
      CC_UC: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_writeback_psr.sv
// ALU writeback stage: handshaked register-file write, selective PSR update, branch conditions.
// Define ALU_WB_CNT_EN to add retire_cnt/stall_cnt performance counters.
module alu_writeback_psr
  import alu_writeback_psr_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_opcode,
  input  logic [DATA_W-1:0] in_result,
  input  logic [4:0]        in_flags,
  input  logic [REG_AW-1:0] in_dest,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  input  logic              wb_ready,
  output logic [4:0]        psr,
  output logic              carry_out,
  input  logic              psr_ld,
  input  logic [4:0]        psr_ld_data,
  input  logic [3:0]        cond,
  output logic              cond_true
`ifdef ALU_WB_CNT_EN
  ,
  output logic [15:0]       retire_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  wb_state_t  state, next_state;
  logic       accept;
  logic       load;
  logic [4:0] mask;
  logic [4:0] psr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = (state == ST_IDLE) || wb_ready;
    accept     = in_valid && in_ready;
    load       = accept && op_is_writeback(in_opcode);
    case (state)
      ST_IDLE: if (load) next_state = ST_HOLD;
      ST_HOLD: if (wb_ready && !load) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  assign wb_en = (state == ST_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_addr <= '0;
      wb_data <= '0;
    end else if (load) begin
      wb_addr <= in_dest;
      wb_data <= in_result;
    end
  end

  // Per-bit select so flags outside the mask (including x from NOP) never reach the PSR.
  always_comb begin
    mask     = psr_update_mask(in_opcode);
    psr_next = psr;
    for (int i = 0; i < 5; i++) begin
      if (mask[i]) psr_next[i] = in_flags[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      psr <= '0;
    else if (psr_ld) psr <= psr_ld_data;
    else if (accept) psr <= psr_next;
  end

  assign carry_out = psr[FLG_C];

  alu_writeback_psr_cond_eval u_cond_eval (
    .psr       (psr),
    .cond      (cond),
    .cond_true (cond_true)
  );

`ifdef ALU_WB_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (accept) retire_cnt <= retire_cnt + 16'd1;
      if ((state == ST_HOLD) && !wb_ready) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_writeback_psr.sv
// Directed plus randomized bench for alu_writeback_psr against a behavioural model.
module tb_alu_writeback_psr;
  import alu_writeback_psr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_opcode;
  logic [15:0] in_result;
  logic [4:0]  in_flags;
  logic [3:0]  in_dest;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        wb_ready;
  logic [4:0]  psr;
  logic        carry_out;
  logic        psr_ld;
  logic [4:0]  psr_ld_data;
  logic [3:0]  cond;
  logic        cond_true;
`ifdef ALU_WB_CNT_EN
  logic [15:0] retire_cnt;
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  alu_writeback_psr #(.DATA_W(16), .REG_AW(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_result   (in_result),
    .in_flags    (in_flags),
    .in_dest     (in_dest),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .wb_ready    (wb_ready),
    .psr         (psr),
    .carry_out   (carry_out),
    .psr_ld      (psr_ld),
    .psr_ld_data (psr_ld_data),
    .cond        (cond),
    .cond_true   (cond_true)
`ifdef ALU_WB_CNT_EN
    ,
    .retire_cnt  (retire_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  // Opcode classes, straight from the instruction-set description.
  logic [7:0] cls_cz[$]  = '{ADDU, ADDUI, ADDCU, ADDCUI};
  logic [7:0] cls_fz[$]  = '{ADD, ADDI, ADDC, ADDCI, SUB, SUBI};
  logic [7:0] cls_cmp[$] = '{CMP, CMPI, CMPU, CMPUI};
  logic [7:0] cls_z[$]   = '{AND, ANDI, OR, ORI, XOR, XORI, NOT};
  logic [7:0] cls_sh[$]  = '{LSH, LSHI, RSH, RSHI, ALSH, ALSHI, ARSH, ARSHI};
  logic [7:0] all_ops[$];

  int n_pass = 0;
  int n_total = 0;

  // Reference state
  logic        m_pend;
  logic [3:0]  m_addr;
  logic [15:0] m_data;
  logic [4:0]  m_psr;
  int          m_retire;
  int          m_stall;

  function automatic bit in_list(input logic [7:0] op, input logic [7:0] lst[$]);
    foreach (lst[i]) if (lst[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [4:0] ref_mask(input logic [7:0] op);
    logic [4:0] m;
    m = '0;
    if (in_list(op, cls_cz))  begin m[FLG_C] = 1'b1; m[FLG_Z] = 1'b1; end
    if (in_list(op, cls_fz))  begin m[FLG_F] = 1'b1; m[FLG_Z] = 1'b1; end
    if (in_list(op, cls_cmp)) begin m[FLG_N] = 1'b1; m[FLG_L] = 1'b1; m[FLG_Z] = 1'b1; end
    if (in_list(op, cls_z))   m[FLG_Z] = 1'b1;
    return m;
  endfunction

  function automatic bit ref_writes(input logic [7:0] op);
    return in_list(op, cls_cz) || in_list(op, cls_fz) || in_list(op, cls_z) || in_list(op, cls_sh);
  endfunction

  function automatic logic ref_cond(input logic [4:0] p, input logic [3:0] c);
    logic n, l, f, cy, z;
    {z, cy, f, l, n} = p;
    case (c)
      4'd0: return z;
      4'd1: return !z;
      4'd2: return cy;
      4'd3: return !cy;
      4'd4: return l;
      4'd5: return !l;
      4'd6: return n;
      4'd7: return !n;
      4'd8: return f;
      4'd9: return !f;
      4'd10: return !n && !z;
      4'd11: return n || z;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pend = 1'b0; m_addr = '0; m_data = '0; m_psr = '0;
    m_retire = 0; m_stall = 0;
  endtask

  task automatic check_outputs();
    chk("wb_en", 32'(wb_en), 32'(m_pend));
    if (m_pend) begin
      chk("wb_addr", 32'(wb_addr), 32'(m_addr));
      chk("wb_data", 32'(wb_data), 32'(m_data));
    end
    chk("psr", 32'(psr), 32'(m_psr));
    chk("carry_out", 32'(carry_out), 32'(m_psr[FLG_C]));
`ifdef ALU_WB_CNT_EN
    chk("retire_cnt", 32'(retire_cnt), 32'(m_retire[15:0]));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall[15:0]));
`endif
  endtask

  // One clock: check registered outputs, drive inputs, check combinational outputs, advance model.
  task automatic cycle(input logic v, input logic [7:0] op, input logic [15:0] res,
                       input logic [4:0] fl, input logic [3:0] dst, input logic wr,
                       input logic ld, input logic [4:0] ldd, input logic [3:0] cc);
    logic exp_rdy, acc;
    logic [4:0] mk;
    check_outputs();
    in_valid = v; in_opcode = op; in_result = res; in_dest = dst;
    in_flags = (op == NOP) ? 5'bxxxxx : fl;
    wb_ready = wr; psr_ld = ld; psr_ld_data = ldd; cond = cc;
    #1;
    exp_rdy = !m_pend || wr;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("cond_true", 32'(cond_true), 32'(ref_cond(m_psr, cc)));
    acc = v && exp_rdy;
    if (m_pend && !wr) m_stall++;
    if (acc) m_retire++;
    if (m_pend && wr) m_pend = 1'b0;
    if (acc && ref_writes(op)) begin
      m_pend = 1'b1; m_addr = dst; m_data = res;
    end
    mk = ref_mask(op);
    if (ld) m_psr = ldd;
    else if (acc) m_psr = (m_psr & ~mk) | (fl & mk);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    foreach (cls_cz[i])  all_ops.push_back(cls_cz[i]);
    foreach (cls_fz[i])  all_ops.push_back(cls_fz[i]);
    foreach (cls_cmp[i]) all_ops.push_back(cls_cmp[i]);
    foreach (cls_z[i])   all_ops.push_back(cls_z[i]);
    foreach (cls_sh[i])  all_ops.push_back(cls_sh[i]);
    all_ops.push_back(NOP);

    rst_n = 1'b0; in_valid = 1'b0; in_opcode = NOP; in_result = '0; in_flags = '0;
    in_dest = '0; wb_ready = 1'b0; psr_ld = 1'b0; psr_ld_data = '0; cond = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_wb_en", 32'(wb_en), 32'(0));
    chk("reset_psr", 32'(psr), 32'(0));
    chk("reset_wb_data", 32'(wb_data), 32'(0));
    rst_n = 1'b1;

    // ADDU with C,Z set
    cycle(1, ADDU, 16'h0000, 5'b11000, 4'd3, 1, 0, 0, CC_EQ);
    chk("addu_wb_en", 32'(wb_en), 32'(1));
    chk("addu_wb_addr", 32'(wb_addr), 32'(3));
    chk("addu_psr", 32'(psr), 32'(5'b11000));
    chk("addu_carry", 32'(carry_out), 32'(1));
    // CMP merges N,L,Z; write drains
    cycle(1, CMP, 16'hFFFF, 5'b00011, 4'd5, 1, 0, 0, CC_EQ);
    chk("cmp_wb_en", 32'(wb_en), 32'(0));
    chk("cmp_psr", 32'(psr), 32'(5'b01011));
    cycle(0, NOP, 0, 0, 0, 1, 0, 0, CC_LT);
    cycle(0, NOP, 0, 0, 0, 1, 0, 0, CC_GT);

    // Stall with pending 0x1234, then back-to-back reload
    cycle(1, ADD, 16'h1234, 5'b00000, 4'd1, 1, 0, 0, CC_UC);
    repeat (3) begin
      cycle(1, ADD, 16'h9999, 5'b10100, 4'd2, 0, 0, 0, CC_UC);
      chk("stall_wb_data", 32'(wb_data), 32'(16'h1234));
    end
    cycle(1, ADD, 16'h5678, 5'b00100, 4'd4, 1, 0, 0, CC_FS);
    chk("b2b_wb_data", 32'(wb_data), 32'(16'h5678));
    chk("b2b_wb_en", 32'(wb_en), 32'(1));

    // psr_ld beats an accepted ANDI; write still issued
    cycle(1, ANDI, 16'hABCD, 5'b10000, 4'd7, 1, 1, 5'b00100, CC_NE);
    chk("ld_psr", 32'(psr), 32'(5'b00100));
    chk("ld_wb_addr", 32'(wb_addr), 32'(7));
    chk("ld_wb_data", 32'(wb_data), 32'(16'hABCD));

    // Async reset while HOLD
    cycle(1, XOR, 16'h0F0F, 5'b10000, 4'd9, 1, 0, 0, CC_EQ);
    cycle(0, NOP, 0, 0, 0, 0, 0, 0, CC_EQ);
    rst_n = 1'b0;
    #1;
    chk("arst_wb_en", 32'(wb_en), 32'(0));
    chk("arst_psr", 32'(psr), 32'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, NOP, 0, 0, 0, 1, 0, 0, CC_EQ);
    cycle(0, NOP, 0, 0, 0, 1, 0, 0, CC_EQ);
    chk("post_rst_wb_en", 32'(wb_en), 32'(0));

`ifdef ALU_WB_CNT_EN
    cycle(1, ADD, 16'h0001, 0, 4'd1, 1, 0, 0, CC_EQ);
    cycle(1, ADD, 16'h0002, 0, 4'd1, 0, 0, 0, CC_EQ);
    cycle(1, ADD, 16'h0002, 0, 4'd1, 0, 0, 0, CC_EQ);
    repeat (4) cycle(1, ADD, 16'h0003, 0, 4'd1, 1, 0, 0, CC_EQ);
    cycle(0, NOP, 0, 0, 0, 1, 0, 0, CC_EQ);
    chk("cnt_retire", 32'(retire_cnt), 32'(5));
    chk("cnt_stall", 32'(stall_cnt), 32'(2));
    repeat (65530) cycle(1, CMP, 0, 5'b00001, 0, 1, 0, 0, CC_EQ);
    chk("cnt_near_wrap", 32'(retire_cnt), 32'(16'hFFFF));
    cycle(1, CMP, 0, 5'b00001, 0, 1, 0, 0, CC_EQ);
    chk("cnt_wrap", 32'(retire_cnt), 32'(0));
`endif

    // Randomized traffic
    repeat (400) begin
      logic [7:0] op;
      if ($urandom_range(0, 9) == 0) op = 8'($urandom_range(8'h20, 8'hFF));
      else op = all_ops[$urandom_range(0, all_ops.size() - 1)];
      cycle($urandom_range(0, 3) != 0, op, 16'($urandom), 5'($urandom), 4'($urandom),
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, 5'($urandom), 4'($urandom));
    end
    check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_writeback_psr.md
Name: alu_writeback_psr

Overview:
- Stage directly downstream of the combinational ALU.
- Captures ALU result and 5-bit flags per accepted instruction.
- Maintains the processor status register (PSR), updating it selectively per opcode class, and feeds the carry flag back to the ALU's carryIn.
- Presents a registered, handshaked write to the register file and evaluates branch conditions from the PSR.

Parameters:
- DATA_W, 16, datapath width.
- REG_AW, 4, register-file address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  execute stage has a result this cycle
- in_ready  out  1  stage can accept this cycle
- in_opcode  in  8  opcode of the instruction (same encoding as the ALU)
- in_result  in  DATA_W  ALU result C
- in_flags  in  5  ALU flags; bit map [0]N [1]L [2]F [3]C [4]Z
- in_dest  in  REG_AW  destination register index
- wb_en  out  1  register-file write request
- wb_addr  out  REG_AW  write address
- wb_data  out  DATA_W  write data
- wb_ready  in  1  register file accepts the write this cycle
- psr  out  5  current PSR, same bit map as in_flags
- carry_out  out  1  psr[3], wired to ALU carryIn
- psr_ld  in  1  force-load PSR (interrupt return)
- psr_ld_data  in  5  value for psr_ld
- cond  in  4  branch condition code
- cond_true  out  1  condition evaluated against current PSR (combinational)

Behaviour:
- Reset (async, rst_n=0): psr=0, wb_en=0, wb_addr=0, wb_data=0, state=IDLE. Any pending write is dropped, not replayed.
- Two states: IDLE (no pending write) and HOLD (wb_en=1, waiting for wb_ready).
- in_ready = (state==IDLE) | wb_ready.
- Accept = in_valid & in_ready.
- Writeback opcodes: all except CMP, CMPI, CMPU, CMPUI, NOP and unknown opcodes.
  - Accept of a writeback opcode: wb_addr/wb_data load in_dest/in_result at the edge; state→HOLD.
  - Latency is 1 cycle: wb_en is high in the cycle after accept.
- HOLD with wb_ready=1:
  - Write completes.
  - A simultaneous accept of a writeback opcode reloads the registers and stays in HOLD (back-to-back, full throughput).
  - Otherwise state→IDLE.
- HOLD with wb_ready=0: wb_en, wb_addr and wb_data are held stable; in_ready=0.
- PSR update happens at the accept edge, independent of writeback stall. Update mask by class:
  - ADDU, ADDUI, ADDCU, ADDCUI: C,Z
  - ADD, ADDI, ADDC, ADDCI, SUB, SUBI: F,Z
  - CMP, CMPI, CMPU, CMPUI: N,L,Z
  - AND, ANDI, OR, ORI, XOR, XORI, NOT: Z
  - shifts, NOP, unknown: none
- Masked bits take in_flags; unmasked bits retain their value. Unknown (x) flags from NOP are never sampled.
- psr_ld and an accept in the same cycle: psr_ld wins entirely. The instruction's writeback still proceeds.
- carry_out is registered PSR, so the next accepted instruction sees the updated carry (ADDCU chains work back-to-back).
- cond decode:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
  - 0100 LO L; 0101 HS !L; 0110 LT N; 0111 GE !N
  - 1000 FS F; 1001 FC !F; 1010 GT !N&!Z; 1011 LE N|Z
  - 1110 UC 1; 1100, 1101, 1111 → 0

Optional Feature:
- Macro ALU_WB_CNT_EN.
- Defined:
  - Adds outputs retire_cnt[15:0] (increments on every accept) and stall_cnt[15:0] (increments each cycle state==HOLD & !wb_ready).
  - Both wrap FFFF→0000 and reset to 0.
- Undefined: outputs and counters absent; all other behaviour identical.

Decomposition:
- Shared package:
  - opcode constants (ADD … ARSHI, NOP)
  - flag bit indices (FLG_N=0, FLG_L=1, FLG_F=2, FLG_C=3, FLG_Z=4)
  - condition-code constants
  - PSR update-mask constants per class
- Sub-module cond_eval: purely combinational, psr+cond→cond_true. Reusable by the branch unit.

Test Plan:
- ADDU, in_result=0000, in_flags=11000, dest=3, wb_ready=1 → next cycle wb_en=1, wb_addr=3, wb_data=0000; psr=11000, carry_out=1; cond=0000 → cond_true=1.
- CMP, in_flags=00011 after psr=11000 → wb_en stays 0; psr=01011; cond=0110 → cond_true=1; cond=1010 → 0.
- wb_ready=0 for 3 cycles with pending write 0x1234 → wb_en/wb_data stable, in_ready=0 for 3 cycles; wb_ready=1 with in_valid=1 (ADD 0x5678) → next cycle wb_data=5678.
- psr_ld=1, psr_ld_data=00100 in the same cycle as accepted ANDI with flags 10000 → psr=00100; ANDI write still issued.
- rst_n low mid-HOLD → wb_en=0 and psr=0 immediately (async); pending write not reissued after release.
- ALU_WB_CNT_EN: 5 accepts plus 2 stall cycles → retire_cnt=5, stall_cnt=2; preload near FFFF → wraps to 0000.
